store_buffer: RTL

Posted-write buffer between the 16-bit single-cycle core's data-memory port (`memwrite`, `dataadr`, `writedata`) and the data memory. Each core store is captured in one cycle into a small FIFO. The FIFO drains to memory over a valid/ready handshake, so a slow or multi-cycle memory does not stretch the core's cycle. When the buffer is full, the block stalls the core. Optional store-to-load forwarding keeps loads coherent with stores that have not yet drained.

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/store_buffer_fwd.sv | 36 +++
 rtl/store_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the posted-write store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 16;
    localparam int SB_DW    = 16;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Youngest-match search over the buffered stores for store-to-load forwarding.
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic [DEPTH-1:0][AW-1:0]     addrs,
    input  logic [DEPTH-1:0][DW-1:0]     datas,
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [AW-1:0]                lookup,
    output logic                         hit,
    output logic [DW-1:0]                data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && addrs[idx] == lookup) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and memory.
// Define STORE_BUFFER_FWD_EN to build store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [AW-1:0]              dataadr,
    input  logic [DW-1:0]              writedata,
    output logic                       stall,
    output logic                       mem_wvalid,
    input  logic                       mem_wready,
    output logic [AW-1:0]              mem_waddr,
    output logic [DW-1:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       idle,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            head, tail;
    logic [CW-1:0]            cnt;
    logic                     enq, deq;

    // Full blocks enqueue regardless of a same-cycle dequeue: no ready-to-stall path.
    assign stall      = (cnt == CW'(DEPTH));
    assign mem_wvalid = (cnt != '0);
    assign mem_waddr  = addr_q[head];
    assign mem_wdata  = data_q[head];
    assign count      = cnt;
    assign idle       = (cnt == '0);
    assign enq        = memwrite && !stall;
    assign deq        = mem_wvalid && mem_wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
        end else begin
            if (enq) begin
                addr_q[tail] <= dataadr;
                data_q[tail] <= writedata;
                tail         <= tail + 1'b1;
            end
            if (deq)
                head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0] vmask;

    // Slot i is live when its distance from head is below the occupancy.
    always_comb begin
        vmask = '0;
        for (int i = 0; i < DEPTH; i++)
            vmask[i] = ({1'b0, PW'(i) - head} < cnt);
    end

    store_buffer_fwd #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .addrs  (addr_q),
        .datas  (data_q),
        .valid  (vmask),
        .head   (head),
        .lookup (dataadr),
        .hit    (fwd_hit),
        .data   (fwd_data)
    );
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule
